// File: rtl/mem_wb_writeback_if.sv
// MEM-stage to MEM/WB bus: one instruction's memory-stage results per cycle.
interface mem_wb_writeback_if #(
    parameter int XLEN = 32
);
    logic            m_valid;
    logic            m_reg_write;
    logic [4:0]      m_rd;
    logic [1:0]      m_wb_sel;
    logic [2:0]      m_funct3;
    logic [XLEN-1:0] m_alu_result;
    logic [XLEN-1:0] m_mem_rdata;
    logic [XLEN-1:0] m_pc;

    modport master (
        output m_valid, m_reg_write, m_rd, m_wb_sel, m_funct3,
               m_alu_result, m_mem_rdata, m_pc
    );
    modport slave (
        input  m_valid, m_reg_write, m_rd, m_wb_sel, m_funct3,
               m_alu_result, m_mem_rdata, m_pc
    );
endinterface

// File: rtl/mem_wb_writeback.sv
// MEM/WB pipeline register plus writeback stage: load alignment/extension,
// writeback mux, register-file write port, forwarding tap, instret counter.
module mem_wb_writeback #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            flush,
    mem_wb_writeback_if.slave mem,
    output logic            reg_write,
    output logic [4:0]      write_reg,
    output logic [XLEN-1:0] write_data,
    output logic [1:0]      pc_sel,
    output logic [XLEN-1:0] pc_out,
    output logic            fwd_valid,
    output logic [4:0]      fwd_rd,
    output logic [XLEN-1:0] fwd_data,
    output logic            wb_fault,
    output logic [31:0]     instret
);
    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_LOAD = 2'b01;
    localparam logic [1:0] WB_JAL  = 2'b10;
    localparam logic [1:0] WB_JALR = 2'b11;

    typedef struct packed {
        logic            valid;
        logic            reg_write;
        logic [4:0]      rd;
        logic [1:0]      wb_sel;
        logic [2:0]      funct3;
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] mem_rdata;
        logic [XLEN-1:0] pc;
    } slot_t;

    slot_t           slot;
    logic [31:0]     instret_q;
    logic            fault;
    logic            capture_retire;
    logic [1:0]      offset;
    logic [7:0]      load_byte;
    logic [15:0]     load_half;
    logic [XLEN-1:0] load_data;

    // Misaligned or illegal load encoding for a given funct3/byte offset.
    function automatic logic load_fault(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            3'b000, 3'b100: return 1'b0;
            3'b001, 3'b101: return off[0];
            3'b010:         return off != 2'b00;
            default:        return 1'b1;
        endcase
    endfunction

    // MEM/WB register: flush beats stall; flush only needs to kill valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot <= '0;
        end else if (flush) begin
            slot.valid <= 1'b0;
        end else if (!stall) begin
            slot <= '{valid:      mem.m_valid,
                      reg_write:  mem.m_reg_write,
                      rd:         mem.m_rd,
                      wb_sel:     mem.m_wb_sel,
                      funct3:     mem.m_funct3,
                      alu_result: mem.m_alu_result,
                      mem_rdata:  mem.m_mem_rdata,
                      pc:         mem.m_pc};
        end
    end

    // An instruction is counted on the edge that captures it, so a held
    // slot counts exactly once and a flushed capture never counts.
    assign capture_retire = mem.m_valid &
                            !((mem.m_wb_sel == WB_LOAD) &&
                              load_fault(mem.m_funct3, mem.m_alu_result[1:0]));

    // Retired-instruction counter; wraps naturally at 2^32.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            instret_q <= '0;
        else if (!flush && !stall && capture_retire)
            instret_q <= instret_q + 32'd1;
    end

    assign offset    = slot.alu_result[1:0];
    assign load_byte = slot.mem_rdata[{offset, 3'b000} +: 8];
    assign load_half = offset[1] ? slot.mem_rdata[31:16] : slot.mem_rdata[15:0];

    // Load extraction: pick byte/halfword at the offset and extend.
    always_comb begin
        load_data = slot.mem_rdata;
        case (slot.funct3)
            3'b000:  load_data = {{(XLEN-8){load_byte[7]}}, load_byte};
            3'b100:  load_data = {{(XLEN-8){1'b0}}, load_byte};
            3'b001:  load_data = {{(XLEN-16){load_half[15]}}, load_half};
            3'b101:  load_data = {{(XLEN-16){1'b0}}, load_half};
            default: load_data = slot.mem_rdata;
        endcase
    end

    // Writeback mux, control outputs and forwarding tap, all from the slot.
    always_comb begin
        fault      = slot.valid && (slot.wb_sel == WB_LOAD) &&
                     load_fault(slot.funct3, offset);
        write_data = slot.pc + XLEN'(4);
        case (slot.wb_sel)
            WB_ALU:  write_data = slot.alu_result;
            WB_LOAD: write_data = load_data;
            default: write_data = slot.pc + XLEN'(4);
        endcase
        pc_sel = 2'b00;
        if (slot.valid && slot.wb_sel == WB_JAL)  pc_sel = 2'b01;
        if (slot.valid && slot.wb_sel == WB_JALR) pc_sel = 2'b10;
        reg_write = slot.valid & slot.reg_write & (slot.rd != 5'd0) & !fault;
        write_reg = slot.rd;
        pc_out    = slot.pc;
        wb_fault  = fault;
        fwd_valid = reg_write;
        fwd_rd    = slot.rd;
        fwd_data  = write_data;
        instret   = instret_q;
    end
endmodule

// File: tb/tb_mem_wb_writeback.sv
// Directed bench for mem_wb_writeback with an expected-result queue.
module tb_mem_wb_writeback;
    logic        clk = 1'b0;
    logic        reset, stall, flush;
    logic        reg_write, fwd_valid, wb_fault;
    logic [4:0]  write_reg, fwd_rd;
    logic [1:0]  pc_sel;
    logic [31:0] write_data, pc_out, fwd_data, instret;

    mem_wb_writeback_if #(.XLEN(32)) bus ();

    mem_wb_writeback #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .mem(bus.slave),
        .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
        .pc_sel(pc_sel), .pc_out(pc_out), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd),
        .fwd_data(fwd_data), .wb_fault(wb_fault), .instret(instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          bub;      // only control outputs are meaningful
        bit          chk_data; // write_data/fwd_data are meaningful
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] wd;
        logic [1:0]  psel;
        logic [31:0] pc;
        logic        fault;
        bit          retire;
    } exp_t;

    exp_t        q[$];
    exp_t        cur;
    exp_t        bubble;
    logic [31:0] cnt;
    int          total = 0;
    int          bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check_cur(input string tag);
        chk({tag, ".reg_write"}, 32'(reg_write), 32'(cur.rw));
        chk({tag, ".fwd_valid"}, 32'(fwd_valid), 32'(cur.rw));
        chk({tag, ".pc_sel"},    32'(pc_sel),    32'(cur.psel));
        chk({tag, ".wb_fault"},  32'(wb_fault),  32'(cur.fault));
        chk({tag, ".instret"},   instret,        cnt);
        if (!cur.bub) begin
            chk({tag, ".write_reg"}, 32'(write_reg), 32'(cur.rd));
            chk({tag, ".fwd_rd"},    32'(fwd_rd),    32'(cur.rd));
            chk({tag, ".pc_out"},    pc_out,         cur.pc);
        end
        if (cur.chk_data) begin
            chk({tag, ".write_data"}, write_data, cur.wd);
            chk({tag, ".fwd_data"},   fwd_data,   cur.wd);
        end
    endtask

    // Drive one MEM-stage instruction and queue what WB should show for it.
    task automatic issue(input logic v, input logic rw, input logic [4:0] rd,
                         input logic [1:0] wb, input logic [2:0] f3,
                         input logic [31:0] alu, input logic [31:0] rdata,
                         input logic [31:0] pc, input logic erw,
                         input logic [31:0] ewd, input logic [1:0] epsel,
                         input logic efault, input bit eret, input bit edata);
        exp_t e;
        bus.m_valid = v; bus.m_reg_write = rw; bus.m_rd = rd; bus.m_wb_sel = wb;
        bus.m_funct3 = f3; bus.m_alu_result = alu; bus.m_mem_rdata = rdata; bus.m_pc = pc;
        e.bub = !v; e.chk_data = edata; e.rw = erw; e.rd = rd; e.wd = ewd;
        e.psel = epsel; e.pc = pc; e.fault = efault; e.retire = eret;
        q.push_back(e);
    endtask

    // One clock with the given stall/flush, model update, then check.
    task automatic tick(input logic st, input logic fl, input string tag);
        stall = st; flush = fl;
        @(posedge clk);
        if (fl) begin
            if (q.size() > 0) void'(q.pop_front());
            cur = bubble;
        end else if (!st) begin
            if (q.size() > 0) cur = q.pop_front();
            else cur = bubble;
            if (cur.retire) cnt = cnt + 32'd1;
        end
        @(negedge clk);
        check_cur(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        bubble = '{bub: 1'b1, chk_data: 1'b0, rw: 1'b0, rd: 5'd0, wd: 32'd0,
                   psel: 2'b00, pc: 32'd0, fault: 1'b0, retire: 1'b0};
        reset = 1'b1; stall = 1'b0; flush = 1'b0; cnt = '0;
        bus.m_valid = 0; bus.m_reg_write = 0; bus.m_rd = 0; bus.m_wb_sel = 0;
        bus.m_funct3 = 0; bus.m_alu_result = 0; bus.m_mem_rdata = 0; bus.m_pc = 0;
        repeat (2) @(negedge clk);
        cur = '{bub: 1'b0, chk_data: 1'b1, rw: 1'b0, rd: 5'd0, wd: 32'd0,
                psel: 2'b00, pc: 32'd0, fault: 1'b0, retire: 1'b0};
        check_cur("reset");
        reset = 1'b0;

        // ALU writeback
        issue(1, 1, 5'd5, 2'b00, 3'b000, 32'h1234, 32'h0, 32'h40, 1, 32'h1234, 2'b00, 0, 1, 1);
        tick(0, 0, "alu");
        // Loads: sign/zero extension and offsets
        issue(1, 1, 5'd6, 2'b01, 3'b000, 32'h2003, 32'h80FF_0000, 32'h44, 1, 32'hFFFF_FF80, 2'b00, 0, 1, 1);
        tick(0, 0, "lb");
        issue(1, 1, 5'd6, 2'b01, 3'b100, 32'h2003, 32'h80FF_0000, 32'h48, 1, 32'h0000_0080, 2'b00, 0, 1, 1);
        tick(0, 0, "lbu");
        issue(1, 1, 5'd7, 2'b01, 3'b001, 32'h2002, 32'h80FF_0000, 32'h4C, 1, 32'hFFFF_80FF, 2'b00, 0, 1, 1);
        tick(0, 0, "lh");
        issue(1, 1, 5'd7, 2'b01, 3'b101, 32'h2002, 32'h80FF_0000, 32'h50, 1, 32'h0000_80FF, 2'b00, 0, 1, 1);
        tick(0, 0, "lhu");
        issue(1, 1, 5'd8, 2'b01, 3'b000, 32'h2001, 32'h1234_5678, 32'h54, 1, 32'h0000_0056, 2'b00, 0, 1, 1);
        tick(0, 0, "lb1");
        issue(1, 1, 5'd8, 2'b01, 3'b010, 32'h1000, 32'hDEAD_BEEF, 32'h58, 1, 32'hDEAD_BEEF, 2'b00, 0, 1, 1);
        tick(0, 0, "lw");
        // Faulting loads: no write, no count
        issue(1, 1, 5'd9, 2'b01, 3'b010, 32'h1002, 32'hDEAD_BEEF, 32'h5C, 0, 32'h0, 2'b00, 1, 0, 0);
        tick(0, 0, "lw_mis");
        issue(1, 1, 5'd9, 2'b01, 3'b110, 32'h1000, 32'hDEAD_BEEF, 32'h60, 0, 32'h0, 2'b00, 1, 0, 0);
        tick(0, 0, "ill110");
        issue(1, 1, 5'd9, 2'b01, 3'b001, 32'h1001, 32'hDEAD_BEEF, 32'h64, 0, 32'h0, 2'b00, 1, 0, 0);
        tick(0, 0, "lh_mis");
        // Jumps
        issue(1, 1, 5'd1, 2'b10, 3'b000, 32'h0, 32'h0, 32'h100, 1, 32'h104, 2'b01, 0, 1, 1);
        tick(0, 0, "jal");
        issue(1, 1, 5'd0, 2'b10, 3'b000, 32'h0, 32'h0, 32'h100, 0, 32'h104, 2'b01, 0, 1, 1);
        tick(0, 0, "jal_x0");
        issue(1, 1, 5'd3, 2'b11, 3'b000, 32'h0, 32'h0, 32'hFFFF_FFFC, 1, 32'h0, 2'b10, 0, 1, 1);
        tick(0, 0, "jalr_wrap");
        issue(0, 1, 5'd3, 2'b10, 3'b000, 32'h0, 32'h0, 32'h200, 0, 32'h0, 2'b00, 0, 0, 0);
        tick(0, 0, "invalid");
        // Stall 3 cycles, then stall+flush: flush wins
        issue(1, 1, 5'd7, 2'b00, 3'b000, 32'hABCD, 32'h0, 32'h300, 1, 32'hABCD, 2'b00, 0, 1, 1);
        tick(0, 0, "stall_cap");
        issue(1, 1, 5'd11, 2'b00, 3'b000, 32'h5555, 32'h0, 32'h304, 1, 32'h5555, 2'b00, 0, 1, 1);
        tick(1, 0, "stall1");
        tick(1, 0, "stall2");
        tick(1, 0, "stall3");
        tick(1, 1, "stall_flush");
        // Reset asserted mid-stall clears at once
        issue(1, 1, 5'd9, 2'b00, 3'b000, 32'h9999, 32'h0, 32'h400, 1, 32'h9999, 2'b00, 0, 1, 1);
        tick(0, 0, "pre_rst");
        tick(1, 0, "pre_rst_stall");
        reset = 1'b1;
        #1;
        cnt = '0;
        cur = '{bub: 1'b0, chk_data: 1'b1, rw: 1'b0, rd: 5'd0, wd: 32'd0,
                psel: 2'b00, pc: 32'd0, fault: 1'b0, retire: 1'b0};
        check_cur("async_rst");
        @(negedge clk);
        reset = 1'b0;
        issue(1, 1, 5'd10, 2'b00, 3'b000, 32'h00C0_FFEE, 32'h0, 32'h500, 1, 32'h00C0_FFEE, 2'b00, 0, 1, 1);
        tick(0, 0, "post_rst");
        // instret wrap
        force dut.instret_q = 32'hFFFF_FFFF;
        #1;
        release dut.instret_q;
        cnt = 32'hFFFF_FFFF;
        issue(1, 1, 5'd12, 2'b00, 3'b000, 32'h77, 32'h0, 32'h600, 1, 32'h77, 2'b00, 0, 1, 1);
        tick(0, 0, "wrap");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
